rf_write_port: RTL and testbench

- Owns the regfile's single write port (we3/wa3/wd3) and merges two write sources onto it.
- Source 1: the in-order pipeline writeback stage. It always has priority and is never stalled.
- Source 2: long-latency units (multiply/divide, future cache-miss loads). These return results through an aux valid/ready handshake into a small FIFO.
- Keeps a per-register pending scoreboard so the hazard unit can stall reads of registers whose aux result has not yet been written.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/rf_write_port_if.sv | 51 +++++
 rtl/rf_write_port_aux_fifo.sv | 56 +++++
 rtl/rf_write_port.sv | 101 ++++++++++
 tb/tb_rf_write_port.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared regfile-write types and widths for the MIPS core.
// Used by the regfile, writeback stage, hazard unit and the write-port merger.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] wa;
    logic [DATA_W-1:0]     wd;
  } rf_wr_t;

  // One queued long-latency result awaiting the write port.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] wa;
    logic [DATA_W-1:0]     wd;
  } aux_ent_t;

  localparam int AUX_ENT_W = $bits(aux_ent_t);

endpackage

// File: rtl/rf_write_port_if.sv
// Bundle of the pipeline, issue, aux-result, regfile and scoreboard-query signals
// around the regfile write-port merger.
interface rf_write_port_if;
  import mips_pkg::*;

  logic                  pipe_we;
  logic [REG_ADDR_W-1:0] pipe_wa;
  logic [DATA_W-1:0]     pipe_wd;

  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_wa;
  logic                  issue_ready;

  logic                  aux_valid;
  logic [REG_ADDR_W-1:0] aux_wa;
  logic [DATA_W-1:0]     aux_wd;
  logic                  aux_ready;

  logic                  we3;
  logic [REG_ADDR_W-1:0] wa3;
  logic [DATA_W-1:0]     wd3;

  logic [REG_ADDR_W-1:0] qa1;
  logic [REG_ADDR_W-1:0] qa2;
  logic                  busy1;
  logic                  busy2;
  logic                  waw_err;

  modport slave (
    input  pipe_we, pipe_wa, pipe_wd,
    input  issue_valid, issue_wa,
    output issue_ready,
    input  aux_valid, aux_wa, aux_wd,
    output aux_ready,
    output we3, wa3, wd3,
    input  qa1, qa2,
    output busy1, busy2, waw_err
  );

  modport master (
    output pipe_we, pipe_wa, pipe_wd,
    output issue_valid, issue_wa,
    input  issue_ready,
    output aux_valid, aux_wa, aux_wd,
    input  aux_ready,
    input  we3, wa3, wd3,
    output qa1, qa2,
    input  busy1, busy2, waw_err
  );

endinterface

// File: rtl/rf_write_port_aux_fifo.sv
// Small synchronous FIFO holding aux results until the write port is free.
// Head is presented combinationally; push/pop are ignored when full/empty.
module aux_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage is left unreset; count and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_push && !reset) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rf_write_port.sv
// Regfile write-port merger: pipeline writeback has priority, aux results drain
// from a FIFO in idle cycles, and a pending scoreboard tracks outstanding aux writes.
module rf_write_port
  import mips_pkg::*;
#(
  parameter int AUX_DEPTH = 2
) (
  input logic           clk,
  input logic           reset,
  rf_write_port_if.slave bus
);

  localparam int PTR_W = $clog2(AUX_DEPTH);

  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic           w_issue_acc;
  aux_ent_t       w_aux_in;
  aux_ent_t       w_head;
  logic [AUX_ENT_W-1:0] w_head_bits;
  rf_wr_t         w_wr;
  logic [31:0]    r_pending;
  logic [31:0]    w_pending_nxt;
  logic           r_waw_err;

  initial begin : p_param_chk
    assert (AUX_DEPTH >= 2 && (1 << PTR_W) == AUX_DEPTH);
  end

  assign w_aux_in.wa = bus.aux_wa;
  assign w_aux_in.wd = bus.aux_wd;
  assign w_head      = aux_ent_t'(w_head_bits);

  aux_fifo #(
    .DEPTH (AUX_DEPTH),
    .W     (AUX_ENT_W)
  ) u_aux_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_aux_in),
    .o_head  (w_head_bits),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Handshakes are held low throughout reset so nothing is accepted into a state being cleared.
  assign bus.aux_ready   = !reset && !w_full;
  assign bus.issue_ready = !reset &&
                           (!r_pending[bus.issue_wa] || bus.issue_wa == REG_ZERO);
  assign w_push      = bus.aux_valid && bus.aux_ready;
  assign w_pop       = !reset && !bus.pipe_we && !w_empty;
  assign w_issue_acc = bus.issue_valid && bus.issue_ready;

  always_comb begin
    w_wr = '0;
    if (reset) begin
      w_wr = '0;
    end else if (bus.pipe_we) begin
      w_wr.we = (bus.pipe_wa != REG_ZERO);
      w_wr.wa = bus.pipe_wa;
      w_wr.wd = bus.pipe_wd;
    end else if (!w_empty) begin
      w_wr.we = (w_head.wa != REG_ZERO);
      w_wr.wa = w_head.wa;
      w_wr.wd = w_head.wd;
    end
  end

  assign bus.we3 = w_wr.we;
  assign bus.wa3 = w_wr.wa;
  assign bus.wd3 = w_wr.wd;

  // Clear-on-pop and set-on-issue never hit the same register: the issue is refused while pending.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_pop && w_head.wa != REG_ZERO)
      w_pending_nxt[w_head.wa] = 1'b0;
    if (w_issue_acc && bus.issue_wa != REG_ZERO)
      w_pending_nxt[bus.issue_wa] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
      r_waw_err <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      if (bus.pipe_we && bus.pipe_wa != REG_ZERO && r_pending[bus.pipe_wa])
        r_waw_err <= 1'b1;
    end
  end

  assign bus.busy1   = r_pending[bus.qa1] && (bus.qa1 != REG_ZERO);
  assign bus.busy2   = r_pending[bus.qa2] && (bus.qa2 != REG_ZERO);
  assign bus.waw_err = r_waw_err;

endmodule

// File: tb/tb_rf_write_port.sv
// Self-checking bench for rf_write_port: directed test-plan steps followed by
// random traffic, all checked against a queue/array reference model.
module tb_rf_write_port;

  localparam int DEPTH = 2;

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
  } ent_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  ent_t        mq[$];
  bit          mpend[32];
  bit          mwaw;
  logic [4:0]  outstanding[$];

  rf_write_port_if bus();

  rf_write_port #(.AUX_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    e_we = 1'b0; e_wa = '0; e_wd = '0;
    if (!reset) begin
      if (bus.pipe_we) begin
        e_we = (bus.pipe_wa != 0); e_wa = bus.pipe_wa; e_wd = bus.pipe_wd;
      end else if (mq.size() > 0) begin
        e_we = (mq[0].wa != 0); e_wa = mq[0].wa; e_wd = mq[0].wd;
      end
    end
    chk({tag, ".we3"}, 32'(bus.we3), 32'(e_we));
    chk({tag, ".wa3"}, 32'(bus.wa3), 32'(e_wa));
    chk({tag, ".wd3"}, bus.wd3, e_wd);
    chk({tag, ".aux_ready"}, 32'(bus.aux_ready), 32'(!reset && mq.size() < DEPTH));
    chk({tag, ".issue_ready"}, 32'(bus.issue_ready),
        32'(!reset && (bus.issue_wa == 0 || !mpend[bus.issue_wa])));
    chk({tag, ".busy1"}, 32'(bus.busy1), 32'(mpend[bus.qa1]));
    chk({tag, ".busy2"}, 32'(bus.busy2), 32'(mpend[bus.qa2]));
    chk({tag, ".waw_err"}, 32'(bus.waw_err), 32'(mwaw));
  endtask

  // Applies one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    bit   do_push, do_pop, do_iss;
    ent_t e;
    if (reset) begin
      mq.delete();
      outstanding.delete();
      foreach (mpend[i]) mpend[i] = 1'b0;
      mwaw = 1'b0;
      return;
    end
    do_push = bus.aux_valid && (mq.size() < DEPTH);
    do_pop  = !bus.pipe_we && (mq.size() > 0);
    do_iss  = bus.issue_valid && (bus.issue_wa == 0 || !mpend[bus.issue_wa]);
    if (bus.pipe_we && bus.pipe_wa != 0 && mpend[bus.pipe_wa]) mwaw = 1'b1;
    if (do_pop) begin
      e = mq.pop_front();
      if (e.wa != 0) mpend[e.wa] = 1'b0;
    end
    if (do_iss && bus.issue_wa != 0) begin
      mpend[bus.issue_wa] = 1'b1;
      outstanding.push_back(bus.issue_wa);
    end
    if (do_push) begin
      e.wa = bus.aux_wa; e.wd = bus.aux_wd;
      mq.push_back(e);
      if (outstanding.size() > 0 && outstanding[0] == bus.aux_wa) void'(outstanding.pop_front());
    end
  endtask

  task automatic step(input string tag);
    #1;
    check_all(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.pipe_we = 0; bus.pipe_wa = 0; bus.pipe_wd = 0;
    bus.issue_valid = 0; bus.issue_wa = 0;
    bus.aux_valid = 0; bus.aux_wa = 0; bus.aux_wd = 0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    mwaw = 0;
    foreach (mpend[i]) mpend[i] = 1'b0;
    reset = 1'b1;
    idle_inputs();
    bus.qa1 = 0; bus.qa2 = 0;
    @(negedge clk);
    step("rst0");
    step("rst1");
    reset = 1'b0;

    // Idle after reset
    bus.qa1 = 5; bus.qa2 = 9;
    #1;
    chk("idle.aux_ready", 32'(bus.aux_ready), 32'd1);
    chk("idle.issue_ready", 32'(bus.issue_ready), 32'd1);
    step("idle");

    // Pipe write, then pipe write to $0
    bus.pipe_we = 1; bus.pipe_wa = 8; bus.pipe_wd = 32'h1234;
    #1;
    chk("pipe.we3", 32'(bus.we3), 32'd1);
    chk("pipe.wa3", 32'(bus.wa3), 32'd8);
    chk("pipe.wd3", bus.wd3, 32'h1234);
    step("pipe");
    bus.pipe_wa = 0;
    #1;
    chk("pipe0.we3", 32'(bus.we3), 32'd0);
    step("pipe0");
    bus.pipe_we = 0;

    // Aux lifecycle on $9
    bus.issue_valid = 1; bus.issue_wa = 9; bus.qa1 = 9;
    step("iss9");
    #1;
    chk("iss9b.issue_ready", 32'(bus.issue_ready), 32'd0);
    chk("iss9b.busy1", 32'(bus.busy1), 32'd1);
    step("iss9b");
    bus.issue_valid = 0;
    bus.aux_valid = 1; bus.aux_wa = 9; bus.aux_wd = 32'hCAFEF00D;
    #1;
    chk("aux9.nobypass", 32'(bus.we3), 32'd0);
    step("aux9");
    bus.aux_valid = 0;
    #1;
    chk("aux9w.we3", 32'(bus.we3), 32'd1);
    chk("aux9w.wa3", 32'(bus.wa3), 32'd9);
    chk("aux9w.wd3", bus.wd3, 32'hCAFEF00D);
    chk("aux9w.busy1", 32'(bus.busy1), 32'd1);
    step("aux9w");
    #1;
    chk("aux9c.busy1", 32'(bus.busy1), 32'd0);

    // Priority and fill: pipe holds the port while two results queue
    bus.issue_valid = 1; bus.issue_wa = 10; step("iss10");
    bus.issue_wa = 11; step("iss11");
    bus.issue_valid = 0;
    bus.pipe_we = 1; bus.pipe_wa = 3; bus.pipe_wd = 32'h33;
    bus.aux_valid = 1; bus.aux_wa = 10; bus.aux_wd = 32'hA0A0; step("push10");
    bus.aux_wa = 11; bus.aux_wd = 32'hB1B1; step("push11");
    bus.aux_valid = 0;
    #1;
    chk("full.aux_ready", 32'(bus.aux_ready), 32'd0);
    step("full");
    bus.pipe_we = 0;
    #1;
    chk("drain10.wa3", 32'(bus.wa3), 32'd10);
    step("drain10");
    #1;
    chk("drain11.wa3", 32'(bus.wa3), 32'd11);
    chk("drain11.wd3", bus.wd3, 32'hB1B1);
    step("drain11");
    #1;
    chk("drained.we3", 32'(bus.we3), 32'd0);

    // Aux result to $0 is queued but never enables a write
    bus.aux_valid = 1; bus.aux_wa = 0; bus.aux_wd = 32'hFFFF; step("aux0");
    bus.aux_valid = 0;
    #1;
    chk("aux0.we3", 32'(bus.we3), 32'd0);
    step("aux0w");

    // WAW on $12
    bus.issue_valid = 1; bus.issue_wa = 12; step("iss12");
    bus.issue_valid = 0;
    bus.pipe_we = 1; bus.pipe_wa = 12; bus.pipe_wd = 32'h12; step("waw");
    bus.pipe_we = 0;
    #1;
    chk("waw.set", 32'(bus.waw_err), 32'd1);
    step("waw1");
    step("waw2");
    #1;
    chk("waw.sticky", 32'(bus.waw_err), 32'd1);

    // Reset with a queued entry discards it
    bus.issue_valid = 1; bus.issue_wa = 13; step("iss13");
    bus.issue_valid = 0;
    bus.pipe_we = 1; bus.pipe_wa = 4; bus.pipe_wd = 32'h4;
    bus.aux_valid = 1; bus.aux_wa = 13; bus.aux_wd = 32'hD00D; step("push13");
    bus.aux_valid = 0; bus.pipe_we = 0;
    reset = 1; bus.qa1 = 13;
    #1;
    chk("rst.we3", 32'(bus.we3), 32'd0);
    step("rstq");
    reset = 0;
    #1;
    chk("postrst.we3", 32'(bus.we3), 32'd0);
    chk("postrst.busy1", 32'(bus.busy1), 32'd0);
    chk("postrst.waw", 32'(bus.waw_err), 32'd0);
    step("postrst");

    // Random traffic against the model
    for (int cyc = 0; cyc < 400; cyc++) begin
      reset = (cyc == 200);
      bus.pipe_we = ($urandom_range(0, 2) == 0);
      bus.pipe_wa = 5'($urandom_range(0, 31));
      bus.pipe_wd = $urandom;
      bus.issue_valid = ($urandom_range(0, 2) == 0);
      bus.issue_wa = 5'($urandom_range(0, 15));
      bus.aux_valid = (outstanding.size() > 0) && ($urandom_range(0, 1) == 1);
      bus.aux_wa = (outstanding.size() > 0) ? outstanding[0] : 5'd0;
      bus.aux_wd = $urandom;
      bus.qa1 = 5'($urandom_range(0, 15));
      bus.qa2 = 5'($urandom_range(0, 31));
      step("rnd");
    end
    reset = 0;
    idle_inputs();
    step("end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
